ins_step_ctrl: RTL

//  Instruction register + multicycle step counter for the multicycle RISC core.

---
 rtl/ins_step_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/ins_step_ctrl.sv
//  +------------------------------------------------------------------------+
//  | Module   : ins_step_ctrl                                               |
//  | Purpose  : Instruction register and multicycle step counter for the    |
//  |            multicycle RISC core. Latches the fetched instruction at    |
//  |            step 0 and sequences the step count until Buff_PC (or the   |
//  |            MAX_STEP watchdog) returns the core to fetch.               |
//  | Options  : HALT_DETECT_EN - when defined, an HLT instruction           |
//  |            (InsM=5'b11100, InsL=2'b01) parks the core in Halted        |
//  |            until reset. When undefined, Halted is always 0.            |
//  | Revision : 1.0  initial release                                        |
//  +------------------------------------------------------------------------+
`default_nettype none

module ins_step_ctrl #(
  parameter int unsigned INS_W    = 16,
  parameter logic [2:0]  MAX_STEP = 3'd5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INS_W-1:0] InsIn,
  input  logic             InsValid,
  input  logic             Buff_PC,
  output logic [2:0]       Cnt,
  output logic [4:0]       InsM,
  output logic [1:0]       InsL,
  output logic [INS_W-1:0] InsR,
  output logic             Fetch,
  output logic             StepErr,
  output logic             Halted
);

`ifdef HALT_DETECT_EN
  localparam bit c_HALT_EN = 1'b1;
`else
  localparam bit c_HALT_EN = 1'b0;
`endif

  localparam logic [2:0] c_STEP_FETCH = 3'd0;
  localparam logic [2:0] c_STEP_FIRST = 3'd1;

  logic [2:0]       cnt_q, cnt_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic             err_q, err_d;
  logic             halted_q, halted_d;
  logic             w_is_hlt;

  // HLT decode on the latched word; constant 0 when halt detection is built out
  assign w_is_hlt = c_HALT_EN && (ins_q[15:11] == 5'b11100) && (ins_q[1:0] == 2'b01);

  // Next-state: fetch at step 0, otherwise Buff_PC beats the watchdog beats increment
  always_comb begin
    cnt_d    = cnt_q;
    ins_d    = ins_q;
    err_d    = err_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (cnt_q == c_STEP_FETCH) begin
        // Buff_PC has no meaning during fetch; stall until the word arrives
        if (InsValid) begin
          ins_d = InsIn;
          cnt_d = c_STEP_FIRST;
        end
      end else if (Buff_PC) begin
        cnt_d = c_STEP_FETCH;
        if (w_is_hlt) begin
          halted_d = 1'b1;
        end
      end else if (cnt_q == MAX_STEP) begin
        // Decoder never ended the instruction: force refetch and flag it
        cnt_d = c_STEP_FETCH;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= c_STEP_FETCH;
      ins_q    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ins_q    <= ins_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  assign Cnt     = cnt_q;
  assign InsR    = ins_q;
  assign InsM    = ins_q[15:11];
  assign InsL    = ins_q[1:0];
  assign StepErr = err_q;
  assign Halted  = halted_q;
  assign Fetch   = (cnt_q == c_STEP_FETCH) && !halted_q;

endmodule

`default_nettype wire
